// File: rtl/riscx_mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// default base address and the captured-request record.
package riscx_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // Request fields captured at accept; the word index lives beside it
  // because its width depends on the memory depth.
  typedef struct packed {
    logic        write;
    logic        err;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering. Store side merges store data into the old
// word; load side extracts the addressed byte/half/word and extends it.
module lsu_lane_align
  import riscx_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = old_word[{lane, 3'b000} +: 8];
  assign ld_half = old_word[{lane[1], 4'b0000} +: 16];

  // Lane merge for stores and select/extend for loads; word ignores uns.
  always_comb begin
    merged    = old_word;
    load_data = '0;
    case (size)
      SIZE_B: begin
        merged[{lane, 3'b000} +: 8] = store_data[7:0];
        load_data = uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SIZE_H: begin
        merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
        load_data = uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      SIZE_W: begin
        merged    = store_data;
        load_data = old_word;
      end
      default: begin
        merged    = old_word;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES extra cycles,
// one-cycle valid pulse carrying read data / error.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word loads
// and stores flag an error instead of being silently aligned down).
module data_mem_responder
  import riscx_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [31:0] iAddress,
  input  logic [31:0] iData,
  input  logic [1:0]  iSize,
  input  logic        iUnsigned,
  output logic        oReady,
  output logic        oValid,
  output logic [31:0] oData,
  output logic        oError
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  req_t              req_q, req_cur, req_in;
  logic [IDX_W-1:0]  idx_q, idx_cur;
  logic              accept, enter_resp;

  logic [31:0]       offset, word_off;
  logic              below, beyond, bad_size, misalign;
  logic [1:0]        lane_in;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       old_word, merged, load_data;

  assign oReady = (state == IDLE);
  assign oValid = (state == RESP);
  // A request never slips in while reset is held.
  assign accept = iReq && oReady && !reset;

  // Range check: below-base is caught separately so the wrapped offset
  // can never alias a valid index.
  assign offset   = iAddress - BASE_ADDR;
  assign word_off = offset >> 2;
  assign below    = iAddress < BASE_ADDR;
  assign beyond   = word_off >= 32'(DEPTH_WORDS);
  assign bad_size = (iSize == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((iSize == SIZE_H) && iAddress[0]) ||
                    ((iSize == SIZE_W) && (iAddress[1:0] != 2'b00));
  assign lane_in  = iAddress[1:0];
`else
  assign misalign = 1'b0;
  assign lane_in  = (iSize == SIZE_H) ? {iAddress[1], 1'b0} :
                    (iSize == SIZE_W) ? 2'b00 : iAddress[1:0];
`endif

  logic unused_bits;
  assign unused_bits = ^{offset[1:0], word_off};

  always_comb begin
    req_in       = '0;
    req_in.write = iWrite;
    req_in.err   = below || beyond || bad_size || misalign;
    req_in.size  = iSize;
    req_in.uns   = iUnsigned;
    req_in.lane  = lane_in;
    req_in.data  = iData;
  end

  // With zero wait states the commit edge is the accept edge, so the live
  // inputs are used while idle and the captured copy afterwards.
  always_comb begin
    req_cur = req_q;
    idx_cur = idx_q;
    if (state == IDLE) begin
      req_cur = req_in;
      idx_cur = word_off[IDX_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // Wait-state counter: loaded at accept, counts down while waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            cnt <= 4'd0;
    else if (accept)                      cnt <= WAIT_LOAD;
    else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // Capture request fields at accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      req_q <= req_in;
      idx_q <= word_off[IDX_W-1:0];
    end
  end

  assign old_word = mem[idx_cur];

  lsu_lane_align u_align (
    .size       (req_cur.size),
    .lane       (req_cur.lane),
    .uns        (req_cur.uns),
    .old_word   (old_word),
    .store_data (req_cur.data),
    .merged     (merged),
    .load_data  (load_data)
  );

  // Storage: commit on the edge entering RESP, never on an errored access.
  always_ff @(posedge clock) begin
    if (enter_resp && req_cur.write && !req_cur.err) mem[idx_cur] <= merged;
  end

  // Response data/error, held at zero outside the valid cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oData  <= '0;
      oError <= 1'b0;
    end else if (enter_resp) begin
      oData  <= (req_cur.err || req_cur.write) ? 32'h0 : load_data;
      oError <= req_cur.err;
    end else begin
      oData  <= '0;
      oError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed steps plus random
// traffic checked against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          WS    = 2;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clock, reset, iReq, iWrite, iUnsigned;
  logic [31:0] iAddress, iData;
  logic [1:0]  iSize;
  logic        oReady, oValid, oError;
  logic [31:0] oData;

  logic [7:0]  ref_mem [4*DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .iReq(iReq), .iWrite(iWrite),
    .iAddress(iAddress), .iData(iData), .iSize(iSize), .iUnsigned(iUnsigned),
    .oReady(oReady), .oValid(oValid), .oData(oData), .oError(oError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: errors and data from address arithmetic over a byte array.
  function automatic void model(input bit apply, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] sz, input bit uns,
                                output bit err, output logic [31:0] rd);
    longint off, v;
    int     n;
    logic [31:0] ea;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ea  = a;
    err = (sz == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'd1 && a[0]) err = 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'b00) err = 1'b1;
`else
    if (sz == 2'd1) ea = a & ~32'h1;
    if (sz == 2'd2) ea = a & ~32'h3;
`endif
    off = longint'(ea) - longint'(BASE);
    if (off < 0 || off >= 4*DEPTH) err = 1'b1;
    rd = 32'h0;
    if (!err && !wr) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(off) + i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
      rd = v[31:0];
    end
    if (apply && wr && !err)
      for (int i = 0; i < n; i++) ref_mem[int'(off) + i] = 8'(d >> (8*i));
  endfunction

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!oReady && w < 50) begin @(negedge clock); w++; end
    check({tag, "_ready"}, 32'(oReady), 32'd1);
  endtask

  // One transaction: accept, latency, data, error, return to idle.
  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit uns, input string tag,
                      output logic [31:0] got, output logic got_err);
    bit          eerr;
    logic [31:0] erd;
    int          lat;
    model(1'b1, wr, a, d, sz, uns, eerr, erd);
    wait_ready(tag);
    iReq = 1'b1; iWrite = wr; iAddress = a; iData = d; iSize = sz; iUnsigned = uns;
    @(negedge clock);
    iReq = 1'b0;
    lat = 1;
    while (!oValid && lat < 40) begin @(negedge clock); lat++; end
    got = oData; got_err = oError;
    check({tag, "_lat"}, 32'(lat), 32'(1 + WS));
    check({tag, "_err"}, 32'(oError), 32'(eerr));
    check({tag, "_data"}, oData, erd);
    check({tag, "_busy"}, 32'(oReady), 32'd0);
    @(negedge clock);
    check({tag, "_idle"}, {oData[29:0], oValid, oError}, 32'h0);
  endtask

  initial begin
    logic [31:0] got, exp_w, r_addr;
    logic        gerr;
    bit          eerr;
    int          pulses, first, second;

    reset = 1'b1; iReq = 1'b0; iWrite = 1'b0; iAddress = '0; iData = '0;
    iSize = 2'd0; iUnsigned = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("rst_ready", 32'(oReady), 32'd1);
      check("rst_outs", {oData[29:0], oValid, oError}, 32'h0);
    end

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++) xact(1'b1, BASE + 32'(4*w), $urandom, 2'd2, 1'b0, "fill", got, gerr);

    xact(1'b1, BASE, 32'hDEADBEEF, 2'd2, 1'b0, "sw", got, gerr);
    xact(1'b0, BASE, 32'h0, 2'd2, 1'b0, "lw", got, gerr);
    check("lw_deadbeef", got, 32'hDEADBEEF);

    xact(1'b1, BASE + 32'd5, 32'h80, 2'd0, 1'b0, "sb", got, gerr);
    xact(1'b0, BASE + 32'd5, 32'h0, 2'd0, 1'b0, "lb", got, gerr);
    check("lb_sext", got, 32'hFFFF_FF80);
    xact(1'b0, BASE + 32'd5, 32'h0, 2'd0, 1'b1, "lbu", got, gerr);
    check("lbu_zext", got, 32'h0000_0080);
    xact(1'b1, BASE + 32'd6, 32'h1234, 2'd1, 1'b0, "sh", got, gerr);
    xact(1'b0, BASE + 32'd4, 32'h0, 2'd2, 1'b0, "lw4", got, gerr);
    check("lw4_upper", {8'h0, got[31:8]}, 32'h0012_3480);
    check("lw4_byte4", {24'h0, got[7:0]}, {24'h0, ref_mem[4]});

    xact(1'b0, 32'h1000_FFFC, 32'h0, 2'd2, 1'b0, "below", got, gerr);
    check("below_err", 32'(gerr), 32'd1);
    exp_w = {ref_mem[4*DEPTH-1], ref_mem[4*DEPTH-2], ref_mem[4*DEPTH-3], ref_mem[4*DEPTH-4]};
    xact(1'b1, BASE + 32'(4*DEPTH), 32'h5555_AAAA, 2'd2, 1'b0, "beyond", got, gerr);
    check("beyond_err", 32'(gerr), 32'd1);
    xact(1'b0, BASE + 32'(4*DEPTH-4), 32'h0, 2'd2, 1'b0, "last", got, gerr);
    check("last_unchanged", got, exp_w);

    exp_w = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
    xact(1'b0, BASE + 32'd2, 32'h0, 2'd2, 1'b0, "mis", got, gerr);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_err", 32'(gerr), 32'd1);
`else
    check("mis_aligned", got, exp_w);
`endif

    // Request held high across a pending one: two pulses, WS+2 apart.
    exp_w = {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]};
    wait_ready("busy");
    iReq = 1'b1; iWrite = 1'b0; iAddress = BASE + 32'd4; iSize = 2'd2; iUnsigned = 1'b0;
    pulses = 0; first = -1; second = -1;
    for (int c = 1; c <= 3*(WS+2) + 4; c++) begin
      @(negedge clock);
      if (c == 3 + WS) iReq = 1'b0;
      if (oValid) begin
        pulses++;
        if (first < 0) first = c; else if (second < 0) second = c;
        check("busy_data", oData, exp_w);
      end
    end
    check("busy_pulses", 32'(pulses), 32'd2);
    check("busy_first", 32'(first), 32'(1 + WS));
    check("busy_gap", 32'(second - first), 32'(WS + 2));

    // Reset during WAIT of a store: no response, word untouched.
    r_addr = BASE + 32'h20;
    exp_w = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
    wait_ready("rstw");
    iReq = 1'b1; iWrite = 1'b1; iAddress = r_addr; iData = 32'hCAFE_F00D; iSize = 2'd2;
    @(negedge clock);
    iReq = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clock); if (oValid) pulses++; end
    check("rstw_novalid", 32'(pulses), 32'd0);
    xact(1'b0, r_addr, 32'h0, 2'd2, 1'b0, "rstw_rd", got, gerr);
    check("rstw_unchanged", got, exp_w);

    // Random traffic against the reference model.
    for (int t = 0; t < 150; t++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = BASE - 32'($urandom_range(1, 16));
      else             a = BASE + 32'($urandom_range(0, 4*DEPTH + 7));
      xact(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), "rnd", got, gerr);
    end

    model(1'b0, 1'b0, BASE, 32'h0, 2'd2, 1'b0, eerr, exp_w);
    xact(1'b0, BASE, 32'h0, 2'd2, 1'b0, "final", got, gerr);
    check("final_word", got, exp_w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
